// File: rtl/axi_stream_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_stream_if : minimal AXI-stream bundle (tdata/tvalid/tready/   |
// |                 tlast) with master and slave views.               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface axi_stream_if #(
    parameter int DATA_WIDTH = 1
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/cfg_bitstream_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cfg_bitstream_tx : serializes parallel configuration words        |
// |                    MSB-first onto an AXI-stream with frame count. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cfg_bitstream_tx #(
    parameter int WORD_WIDTH  = 8,
    parameter int DATA_WIDTH  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   in_valid,
    output logic                        in_ready,
    input  wire logic [WORD_WIDTH-1:0]  in_data,
    input  wire logic                   in_last,
    input  wire logic                   abort,
    axi_stream_if.master                m_bitstream,
    output logic                        busy,
    output logic [COUNT_WIDTH-1:0]      frame_beats,
    output logic                        done
);

    localparam int c_BEATS  = WORD_WIDTH / DATA_WIDTH;
    localparam int c_BIDX_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_BIDX_W-1:0] c_LAST_BEAT = c_BIDX_W'(c_BEATS - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [0:0]             r_state;
    logic [WORD_WIDTH-1:0]  r_shift;
    logic [c_BIDX_W-1:0]    r_beat;
    logic                   r_last;
    logic [COUNT_WIDTH-1:0] r_frame_beats;
    logic                   r_done;

    logic w_send;
    logic w_last_beat;
    logic w_hs;
    logic w_tlast;
    logic w_accept;

    assign w_send      = (r_state == c_ST_SEND);
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_hs        = w_send && m_bitstream.tready;
    assign w_tlast     = w_send && r_last && w_last_beat;

    // A refill on the final beat keeps the stream gap-free; abort and reset block acceptance.
    assign in_ready = rst_n && !abort && (!w_send || (w_last_beat && m_bitstream.tready));
    assign w_accept = in_valid && in_ready;

    assign m_bitstream.tvalid = w_send;
    assign m_bitstream.tdata  = r_shift[WORD_WIDTH-1 -: DATA_WIDTH];
    assign m_bitstream.tlast  = w_tlast;

    assign busy        = w_send;
    assign frame_beats = r_frame_beats;
    assign done        = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            r_state       <= c_ST_IDLE;
            r_shift       <= '0;
            r_beat        <= '0;
            r_last        <= 1'b0;
            r_frame_beats <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_hs && w_tlast;

            if (w_hs) begin
                if (w_tlast) begin
                    r_frame_beats <= '0;
                end else if (r_frame_beats != '1) begin
                    r_frame_beats <= r_frame_beats + 1'b1;
                end
            end

            if (w_accept) begin
                r_state <= c_ST_SEND;
                r_shift <= in_data;
                r_beat  <= '0;
                r_last  <= in_last;
            end else if (w_hs) begin
                r_shift <= r_shift << DATA_WIDTH;
                if (w_last_beat) begin
                    r_state <= c_ST_IDLE;
                    r_beat  <= '0;
                    r_last  <= 1'b0;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_bitstream_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cfg_bitstream_tx : randomized bench against a beat-queue model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_cfg_bitstream_tx;

    localparam int c_WW    = 8;
    localparam int c_DW    = 1;
    localparam int c_CW    = 16;
    localparam int c_BEATS = c_WW / c_DW;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [c_WW-1:0]   in_data;
    logic              in_last;
    logic              abort;
    logic              busy;
    logic [c_CW-1:0]   frame_beats;
    logic              done;

    logic              in_valid2;
    logic              in_ready2;
    logic [c_WW-1:0]   in_data2;
    logic              in_last2;
    logic              abort2;
    logic              busy2;
    logic [c_CW-1:0]   frame_beats2;
    logic              done2;

    axi_stream_if #(.DATA_WIDTH(c_DW)) s_if ();
    axi_stream_if #(.DATA_WIDTH(4))    s_if4 ();

    cfg_bitstream_tx #(.WORD_WIDTH(c_WW), .DATA_WIDTH(c_DW), .COUNT_WIDTH(c_CW)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .abort       (abort),
        .m_bitstream (s_if),
        .busy        (busy),
        .frame_beats (frame_beats),
        .done        (done)
    );

    cfg_bitstream_tx #(.WORD_WIDTH(c_WW), .DATA_WIDTH(4), .COUNT_WIDTH(c_CW)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_data     (in_data2),
        .in_last     (in_last2),
        .abort       (abort2),
        .m_bitstream (s_if4),
        .busy        (busy2),
        .frame_beats (frame_beats2),
        .done        (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the word in flight is a queue of pending beats, oldest first.
    typedef struct packed {
        logic [c_DW-1:0] d;
        logic            l;
    } beat_t;

    beat_t           mq[$];
    logic [c_CW-1:0] m_fb   = '0;
    logic            m_done = 1'b0;

    function automatic logic model_ready();
        return rst_n && !abort && (mq.size() == 0 || (mq.size() == 1 && s_if.tready));
    endfunction

    task automatic model_compare();
        logic            exp_v;
        logic [c_DW-1:0] exp_d;
        logic            exp_l;
        exp_v = (mq.size() > 0);
        exp_d = exp_v ? mq[0].d : '0;
        exp_l = exp_v ? mq[0].l : 1'b0;
        check("tvalid",      32'(s_if.tvalid), 32'(exp_v));
        check("tdata",       32'(s_if.tdata),  32'(exp_d));
        check("tlast",       32'(s_if.tlast),  32'(exp_l));
        check("in_ready",    32'(in_ready),    32'(model_ready()));
        check("busy",        32'(busy),        32'(exp_v));
        check("frame_beats", 32'(frame_beats), 32'(m_fb));
        check("done",        32'(done),        32'(m_done));
    endtask

    task automatic model_edge();
        logic acc;
        logic hs;
        acc = in_valid && model_ready();
        hs  = (mq.size() > 0) && s_if.tready;
        if (!rst_n || abort) begin
            mq.delete();
            m_fb   = '0;
            m_done = 1'b0;
        end else begin
            m_done = hs && mq[0].l;
            if (hs) begin
                if (mq[0].l)            m_fb = '0;
                else if (m_fb != '1)    m_fb = m_fb + 1'b1;
                void'(mq.pop_front());
            end
            if (acc) begin
                for (int b = 0; b < c_BEATS; b++) begin
                    beat_t nb;
                    nb.d = c_DW'(in_data >> (c_WW - c_DW * (b + 1)));
                    nb.l = in_last && (b == c_BEATS - 1);
                    mq.push_back(nb);
                end
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [c_WW-1:0] d, input logic l,
                       input logic tr, input logic ab, input logic rn);
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        s_if.tready = tr;
        abort       = ab;
        rst_n       = rn;
        @(negedge clk);
        model_compare();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        in_valid2    = 1'b0;
        in_data2     = '0;
        in_last2     = 1'b0;
        abort2       = 1'b0;
        s_if4.tready = 1'b1;

        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Single-word frame 0xA5.
        cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(10);

        // Back-to-back 0xF0, 0x0F.
        cyc(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(10);

        // 0xC3 with a 3-cycle stall at beat 3.
        cyc(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);

        // Abort at beat 5 of 0xFF, then 0x81.
        cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(4);
        cyc(1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        cyc(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(10);

        // Reset mid-word.
        cyc(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                8'($urandom),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 99) < 2),
                ($urandom_range(0, 199) != 0));
        end
        idle(12);

        // 4-bit beats: 0x3C -> 0x3 then 0xC.
        in_valid2 = 1'b1;
        in_data2  = 8'h3C;
        in_last2  = 1'b1;
        @(negedge clk);
        check("dw4 idle ready", 32'(in_ready2), 32'd1);
        check("dw4 idle valid", 32'(s_if4.tvalid), 32'd0);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("dw4 beat0 data", 32'(s_if4.tdata), 32'h3);
        check("dw4 beat0 last", 32'(s_if4.tlast), 32'd0);
        check("dw4 beat0 valid", 32'(s_if4.tvalid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("dw4 beat1 data", 32'(s_if4.tdata), 32'hC);
        check("dw4 beat1 last", 32'(s_if4.tlast), 32'd1);
        check("dw4 beat1 count", 32'(frame_beats2), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("dw4 done", 32'(done2), 32'd1);
        check("dw4 count clear", 32'(frame_beats2), 32'd0);
        check("dw4 valid drop", 32'(s_if4.tvalid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("dw4 done one cycle", 32'(done2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
